systolic_sched: RTL and testbench

Sequencer for the N×M systolic PE array. It runs one matrix-multiply pass per `start`: drives skewed per-row activation and per-column weight feed enables and buffer indices, waits out the array pipeline latency, then pulses `done`. It sits between the host/command interface and the activation/weight buffers that feed the array edges. It holds no datapath itself; all outputs are control.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/skew_lane_dec.sv | 32 +++
 rtl/systolic_sched.sv | 116 +++++++++++
 tb/tb_systolic_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU control slice: FSM state encoding, width helper
// and default array dimensions used by both the scheduler and the array top.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int unsigned DEF_ROWS = 4;
    localparam int unsigned DEF_COLS = 4;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int unsigned clogW(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/skew_lane_dec.sv
// Per-lane skewed feed decode: lane i is enabled for K cycles starting at t=i,
// presenting buffer index t-i while enabled and 0 otherwise.
module skew_lane_dec #(
    parameter int unsigned LANES = 4,
    parameter int unsigned IW    = 4,
    parameter int unsigned KW    = 5,
    parameter int unsigned TW    = 5
) (
    input  logic [TW-1:0]       t,
    input  logic [KW-1:0]       k,
    input  logic                inFeed,
    output logic [LANES-1:0]    en,
    output logic [LANES*IW-1:0] idx
);

    logic [TW-1:0] diff;

    always_comb begin
        en   = '0;
        idx  = '0;
        diff = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            diff = t - TW'(i);
            // t >= i guards the subtraction, so diff < K is the upper window bound
            if (inFeed && (t >= TW'(i)) && (diff < TW'(k))) begin
                en[i]           = 1'b1;
                idx[i*IW +: IW] = diff[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/systolic_sched.sv
// Pass sequencer for the systolic array: IDLE -> FEED (K+S cycles) -> DRAIN
// (PIPE_LAT cycles) -> DONE (one cycle). Outputs decode from registered state only.
module systolic_sched
    import tpu_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned K_MAX    = 16,
    parameter int unsigned PIPE_LAT = 8,
    parameter int unsigned IW       = clogW(K_MAX),
    parameter int unsigned KW       = clogW(K_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 abort,
    output logic [ROWS-1:0]      a_en,
    output logic [ROWS*IW-1:0]   a_idx,
    output logic [COLS-1:0]      w_en,
    output logic [COLS*IW-1:0]   w_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned MAXD = (ROWS > COLS) ? ROWS : COLS;
    localparam int unsigned S    = MAXD - 1;
    localparam int unsigned TW   = clogW(K_MAX + S + PIPE_LAT + 1);

    sched_state_t  state;
    logic [TW-1:0] t;
    logic [KW-1:0] kReg;
    logic [TW-1:0] feedLast;
    logic [KW-1:0] kClamped;

    assign feedLast = TW'(kReg) + TW'(S) - TW'(1);
    assign kClamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            t     <= '0;
            kReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    t <= '0;
                    if (start) begin
                        if (k_len == '0) begin
                            state <= DONE;
                        end else begin
                            state <= FEED;
                            kReg  <= kClamped;
                        end
                    end
                end
                FEED: begin
                    if (abort) begin
                        state <= IDLE;
                        t     <= '0;
                    end else if (t == feedLast) begin
                        state <= DRAIN;
                        t     <= '0;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        t     <= '0;
                    end else if (t == TW'(PIPE_LAT - 1)) begin
                        state <= DONE;
                        t     <= '0;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    t     <= '0;
                end
            endcase
        end
    end

    assign busy = (state == FEED) || (state == DRAIN);
    assign done = (state == DONE);

    skew_lane_dec #(
        .LANES (ROWS),
        .IW    (IW),
        .KW    (KW),
        .TW    (TW)
    ) uRowDec (
        .t      (t),
        .k      (kReg),
        .inFeed (state == FEED),
        .en     (a_en),
        .idx    (a_idx)
    );

    skew_lane_dec #(
        .LANES (COLS),
        .IW    (IW),
        .KW    (KW),
        .TW    (TW)
    ) uColDec (
        .t      (t),
        .k      (kReg),
        .inFeed (state == FEED),
        .en     (w_en),
        .idx    (w_idx)
    );

endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched at ROWS=COLS=4, K_MAX=16, PIPE_LAT=8:
// table of hand-computed snapshots for a full pass plus corner-case sequences.
module tb_systolic_sched;
    import tpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  k_len;
    logic        abort;
    logic [3:0]  a_en;
    logic [15:0] a_idx;
    logic [3:0]  w_en;
    logic [15:0] w_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    systolic_sched #(
        .ROWS     (4),
        .COLS     (4),
        .K_MAX    (16),
        .PIPE_LAT (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k_len (k_len),
        .abort (abort),
        .a_en  (a_en),
        .a_idx (a_idx),
        .w_en  (w_en),
        .w_idx (w_idx),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  en;
        logic [15:0] idx;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_aEn"},  32'(a_en),  32'h0);
        check({tag, "_aIdx"}, 32'(a_idx), 32'h0);
        check({tag, "_wEn"},  32'(w_en),  32'h0);
        check({tag, "_wIdx"}, 32'(w_idx), 32'h0);
        check({tag, "_busy"}, 32'(busy),  32'h0);
        check({tag, "_done"}, 32'(done),  32'h0);
    endtask

    // K=16 pass with start sampled at cycle 0; table snapshots plus lane windows.
    task automatic runFullPass(input string tag);
        for (int c = 0; c <= 30; c++) begin
            start = (c == 0);
            k_len = 5'd16;
            abort = 1'b0;
            for (int j = 0; j < 12; j++) begin
                if (vecs[j].cyc == c) begin
                    check($sformatf("%s_c%0d_aEn", tag, c),  32'(a_en),  32'(vecs[j].en));
                    check($sformatf("%s_c%0d_aIdx", tag, c), 32'(a_idx), 32'(vecs[j].idx));
                    check($sformatf("%s_c%0d_wEn", tag, c),  32'(w_en),  32'(vecs[j].en));
                    check($sformatf("%s_c%0d_wIdx", tag, c), 32'(w_idx), 32'(vecs[j].idx));
                    check($sformatf("%s_c%0d_busy", tag, c), 32'(busy),  32'(vecs[j].busy));
                    check($sformatf("%s_c%0d_done", tag, c), 32'(done),  32'(vecs[j].done));
                end
            end
            check($sformatf("%s_c%0d_aEn0", tag, c), 32'(a_en[0]), 32'(c >= 1 && c <= 16));
            check($sformatf("%s_c%0d_aEn3", tag, c), 32'(a_en[3]), 32'(c >= 4 && c <= 19));
            check($sformatf("%s_c%0d_busyWin", tag, c), 32'(busy), 32'(c >= 1 && c <= 27));
            check($sformatf("%s_c%0d_doneWin", tag, c), 32'(done), 32'(c == 28));
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{0,  4'h0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1,  4'h1, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{2,  4'h3, 16'h0001, 1'b1, 1'b0};
        vecs[3]  = '{4,  4'hF, 16'h0123, 1'b1, 1'b0};
        vecs[4]  = '{10, 4'hF, 16'h6789, 1'b1, 1'b0};
        vecs[5]  = '{16, 4'hF, 16'hCDEF, 1'b1, 1'b0};
        vecs[6]  = '{17, 4'hE, 16'hDEF0, 1'b1, 1'b0};
        vecs[7]  = '{19, 4'h8, 16'hF000, 1'b1, 1'b0};
        vecs[8]  = '{20, 4'h0, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{27, 4'h0, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{28, 4'h0, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{29, 4'h0, 16'h0000, 1'b0, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        k_len = '0;
        abort = 1'b0;

        // Reset
        #1;
        checkAllZero("rstHeld");
        step();
        step();
        rst = 1'b1;
        step();
        checkAllZero("rstRel");
        check("rstState", 32'(dut.state), 32'(IDLE));

        // Full pass
        runFullPass("full");

        // Clamp: k_len=31 behaves as K=16
        begin
            int highCnt = 0;
            int doneAt  = -1;
            for (int c = 0; c <= 32; c++) begin
                start = (c == 0);
                k_len = 5'd31;
                if (a_en[0]) highCnt++;
                if (done && doneAt < 0) doneAt = c;
                step();
            end
            start = 1'b0;
            check("clampEn0Cycles", 32'(highCnt), 32'd16);
            check("clampDoneCycle", 32'(doneAt), 32'd28);
        end

        // Short K=1
        for (int c = 0; c <= 15; c++) begin
            logic [3:0] expEn;
            start = (c == 0);
            k_len = 5'd1;
            expEn = (c >= 1 && c <= 4) ? 4'(1 << (c - 1)) : 4'h0;
            check($sformatf("k1_c%0d_aEn", c),  32'(a_en),  32'(expEn));
            check($sformatf("k1_c%0d_wEn", c),  32'(w_en),  32'(expEn));
            check($sformatf("k1_c%0d_aIdx", c), 32'(a_idx), 32'h0);
            check($sformatf("k1_c%0d_done", c), 32'(done),  32'(c == 13));
            step();
        end
        start = 1'b0;

        // Zero length
        for (int c = 0; c <= 3; c++) begin
            start = (c == 0);
            k_len = 5'd0;
            check($sformatf("k0_c%0d_done", c), 32'(done), 32'(c == 1));
            check($sformatf("k0_c%0d_busy", c), 32'(busy), 32'h0);
            check($sformatf("k0_c%0d_en", c),   32'({a_en, w_en}), 32'h0);
            step();
        end
        start = 1'b0;

        // Abort at cycle 10 of a K=16 pass
        begin
            int doneSeen = 0;
            for (int c = 0; c <= 35; c++) begin
                start = (c == 0);
                k_len = 5'd16;
                abort = (c == 10);
                if (c == 10) check("abortPreEn", 32'(a_en), 32'hF);
                if (c >= 11) begin
                    check($sformatf("abort_c%0d_en", c), 32'({a_en, w_en}), 32'h0);
                    check($sformatf("abort_c%0d_busy", c), 32'(busy), 32'h0);
                end
                if (c == 11) check("abortState", 32'(dut.state), 32'(IDLE));
                if (done) doneSeen++;
                step();
            end
            abort = 1'b0;
            start = 1'b0;
            check("abortNoDone", 32'(doneSeen), 32'h0);
        end
        runFullPass("postAbort");

        // Ignored starts during FEED (2), DRAIN (8), DONE (13); accepted at 14
        for (int c = 0; c <= 30; c++) begin
            start = (c == 0) || (c == 2) || (c == 8) || (c == 13) || (c == 14);
            k_len = (c == 0 || c == 14) ? 5'd1 : 5'd16;
            check($sformatf("ign_c%0d_done", c), 32'(done), 32'(c == 13 || c == 27));
            check($sformatf("ign_c%0d_busy", c), 32'(busy),
                  32'((c >= 1 && c <= 12) || (c >= 15 && c <= 26)));
            step();
        end
        start = 1'b0;

        // Reset asserted mid-FEED
        for (int c = 0; c <= 5; c++) begin
            start = (c == 0);
            k_len = 5'd16;
            step();
        end
        start = 1'b0;
        check("midFeedEn", 32'(a_en), 32'hF);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("asyncRst");
        step();
        #2;
        rst = 1'b1;
        step();
        check("postRstState", 32'(dut.state), 32'(IDLE));
        checkAllZero("postRst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
